// File: rtl/itch_payload_assembler.sv
// Assembles a byte-serial ITCH message into a left-aligned payload word; payload_valid is registered one cycle after the last byte.
// No backpressure: accepts one byte per clock, and error conditions are reported as one-cycle pulses.
module itch_payload_assembler #(
  parameter int PAYLOAD_W = 512,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  input  logic                 sof,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 payload_valid,
  output logic [CNT_W-1:0]     msg_len,
  output logic                 length_error,
  output logic                 overrun_error,
  output logic                 unknown_type
);

  localparam int NBYTES = PAYLOAD_W / 8;
  localparam int MAX_TABLE_LEN = 44;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NBYTES);

  if ((PAYLOAD_W % 8) != 0 || MAX_TABLE_LEN > NBYTES || NBYTES > (2**CNT_W - 1)) begin : g_bad_cfg
    $error("itch_payload_assembler: PAYLOAD_W/CNT_W cannot hold the length table");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

  state_t               state;
  logic [PAYLOAD_W-1:0] asm_buf;
  logic [PAYLOAD_W-1:0] byte_shifted;
  logic [PAYLOAD_W-1:0] asm_next;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W-1:0]     exp_len;
  logic                 overrun_armed;
  logic                 type_known;
  logic [CNT_W-1:0]     type_len;

  always_comb begin
    type_known = 1'b1;
    type_len   = '0;
    case (byte_in)
      8'h41:   type_len = CNT_W'(36);  // A
      8'h44:   type_len = CNT_W'(19);  // D
      8'h45:   type_len = CNT_W'(31);  // E
      8'h58:   type_len = CNT_W'(23);  // X
      8'h55:   type_len = CNT_W'(35);  // U
      8'h50:   type_len = CNT_W'(44);  // P
      8'h53:   type_len = CNT_W'(12);  // S
      default: type_known = 1'b0;
    endcase
  end

  // Byte index cnt lands at bits [PAYLOAD_W-1-8*cnt -: 8].
  assign byte_shifted = {byte_in, {(PAYLOAD_W-8){1'b0}}} >> {cnt, 3'b000};
  assign asm_next     = asm_buf | byte_shifted;
  assign cnt_inc      = cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      asm_buf       <= '0;
      cnt           <= '0;
      exp_len       <= '0;
      overrun_armed <= 1'b0;
      payload       <= '0;
      payload_valid <= 1'b0;
      msg_len       <= '0;
      length_error  <= 1'b0;
      overrun_error <= 1'b0;
      unknown_type  <= 1'b0;
    end else begin
      payload_valid <= 1'b0;
      length_error  <= 1'b0;
      overrun_error <= 1'b0;
      unknown_type  <= 1'b0;
      if (byte_valid) begin
        if (sof) begin
          if (state == COLLECT) length_error <= 1'b1;
          overrun_armed <= 1'b0;
          if (type_known) begin
            asm_buf <= {byte_in, {(PAYLOAD_W-8){1'b0}}};
            cnt     <= CNT_W'(1);
            exp_len <= type_len;
            state   <= COLLECT;
          end else begin
            unknown_type <= 1'b1;
            cnt          <= '0;
            state        <= DISCARD;
          end
        end else begin
          case (state)
            COLLECT: begin
              asm_buf <= asm_next;
              cnt     <= (cnt == CNT_MAX) ? cnt : cnt_inc;
              if (cnt_inc == exp_len) begin
                payload       <= asm_next;
                msg_len       <= exp_len;
                payload_valid <= 1'b1;
                overrun_armed <= 1'b1;
                state         <= DISCARD;
              end
            end
            DISCARD: begin
              // Only the first stray byte after a good message is worth reporting.
              if (overrun_armed) begin
                overrun_error <= 1'b1;
                overrun_armed <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_itch_payload_assembler.sv
// Directed bench for itch_payload_assembler: message table plus hand sequences for truncation, back-to-back and reset.
module tb_itch_payload_assembler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         sof = 1'b0;
  logic [511:0] payload;
  logic         payload_valid;
  logic [6:0]   msg_len;
  logic         length_error;
  logic         overrun_error;
  logic         unknown_type;

  itch_payload_assembler #(.PAYLOAD_W(512), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .sof(sof),
    .payload(payload), .payload_valid(payload_valid), .msg_len(msg_len),
    .length_error(length_error), .overrun_error(overrun_error), .unknown_type(unknown_type)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_pv = 0, n_le = 0, n_oe = 0, n_ut = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (payload_valid) n_pv++;
      if (length_error)  n_le++;
      if (overrun_error) n_oe++;
      if (unknown_type)  n_ut++;
    end
  end

  typedef struct {
    logic [7:0] typ;
    int         n;
    bit         gaps;
    int         extra;
    bit         exp_pv;
    int         exp_len;
    int         exp_ut;
    int         exp_oe;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic put(input logic v, input logic s, input logic [7:0] b);
    @(negedge clk);
    byte_valid = v;
    sof        = s;
    byte_in    = b;
  endtask

  function automatic logic [511:0] model(input logic [7:0] t, input int n);
    logic [511:0] m;
    m = '0;
    m[511:504] = t;
    for (int i = 1; i < n; i++) m[511-8*i -: 8] = 8'(i);
    return m;
  endfunction

  task automatic send_msg(input logic [7:0] t, input int n, input bit gaps);
    put(1'b1, 1'b1, t);
    for (int i = 1; i < n; i++) begin
      if (gaps) put(1'b0, 1'b0, 8'hFF);
      put(1'b1, 1'b0, 8'(i));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int pv0, le0, oe0, ut0;
    pv0 = n_pv; le0 = n_le; oe0 = n_oe; ut0 = n_ut;
    send_msg(v.typ, v.n, v.gaps);
    if (v.extra > 0) put(1'b1, 1'b0, 8'hEE);
    else             put(1'b0, 1'b0, 8'h00);
    chk($sformatf("v%0d latency", idx), payload_valid, v.exp_pv);
    for (int k = 1; k < v.extra; k++) put(1'b1, 1'b0, 8'hEE);
    repeat (3) put(1'b0, 1'b0, 8'h00);
    chk($sformatf("v%0d pv_count", idx), n_pv - pv0, v.exp_pv ? 1 : 0);
    chk($sformatf("v%0d le_count", idx), n_le - le0, 0);
    chk($sformatf("v%0d oe_count", idx), n_oe - oe0, v.exp_oe);
    chk($sformatf("v%0d ut_count", idx), n_ut - ut0, v.exp_ut);
    if (v.exp_pv) begin
      chk($sformatf("v%0d msg_len", idx), msg_len, v.exp_len);
      chk($sformatf("v%0d payload", idx), payload, model(v.typ, v.n));
    end
  endtask

  initial begin
    int pv0, le0, oe0, ut0;

    vecs[0] = '{8'h41, 36, 1'b0, 0, 1'b1, 36, 0, 0};  // A contiguous
    vecs[1] = '{8'h53, 12, 1'b1, 0, 1'b1, 12, 0, 0};  // S with gaps
    vecs[2] = '{8'h5A,  6, 1'b0, 0, 1'b0,  0, 1, 0};  // Z unknown + 5 bytes
    vecs[3] = '{8'h58, 23, 1'b0, 0, 1'b1, 23, 0, 0};  // X after unknown
    vecs[4] = '{8'h45, 31, 1'b0, 3, 1'b1, 31, 0, 1};  // E + 3 overrun bytes
    vecs[5] = '{8'h55, 35, 1'b0, 0, 1'b1, 35, 0, 0};  // U

    @(negedge clk);
    chk("reset payload", payload, '0);
    chk("reset msg_len", msg_len, 0);
    chk("reset pulses", {payload_valid, length_error, overrun_error, unknown_type}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) put(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 6; i++) apply(vecs[i], i);

    // D truncated after 10 bytes by an S message
    pv0 = n_pv; le0 = n_le; oe0 = n_oe; ut0 = n_ut;
    send_msg(8'h44, 10, 1'b0);
    put(1'b1, 1'b1, 8'h53);
    put(1'b1, 1'b0, 8'h01);
    chk("trunc le_pulse", length_error, 1);
    chk("trunc no_pv", payload_valid, 0);
    for (int i = 2; i < 12; i++) put(1'b1, 1'b0, 8'(i));
    repeat (3) put(1'b0, 1'b0, 8'h00);
    chk("trunc le_count", n_le - le0, 1);
    chk("trunc pv_count", n_pv - pv0, 1);
    chk("trunc msg_len", msg_len, 12);
    chk("trunc payload", payload, model(8'h53, 12));
    chk("trunc oe_ut", (n_oe - oe0) + (n_ut - ut0), 0);

    // Truncation by an unknown type: both pulses in the same cycle
    send_msg(8'h44, 4, 1'b0);
    put(1'b1, 1'b1, 8'h5A);
    put(1'b0, 1'b0, 8'h00);
    chk("trunc_unk le", length_error, 1);
    chk("trunc_unk ut", unknown_type, 1);
    repeat (2) put(1'b0, 1'b0, 8'h00);

    // Back-to-back S messages with no bubble
    pv0 = n_pv; oe0 = n_oe; le0 = n_le;
    send_msg(8'h53, 12, 1'b0);
    send_msg(8'h53, 12, 1'b0);
    repeat (3) put(1'b0, 1'b0, 8'h00);
    chk("b2b pv_count", n_pv - pv0, 2);
    chk("b2b err_count", (n_oe - oe0) + (n_le - le0), 0);
    chk("b2b payload", payload, model(8'h53, 12));

    // Reset in the middle of an A message, then a full P message
    send_msg(8'h41, 20, 1'b0);
    #2 rst = 1'b1;
    byte_valid = 1'b0;
    sof = 1'b0;
    #1;
    chk("midrst payload", payload, '0);
    chk("midrst msg_len", msg_len, 0);
    chk("midrst pulses", {payload_valid, length_error, overrun_error, unknown_type}, 4'b0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pv0 = n_pv; le0 = n_le; oe0 = n_oe; ut0 = n_ut;
    put(1'b0, 1'b0, 8'h00);
    send_msg(8'h50, 44, 1'b0);
    put(1'b0, 1'b0, 8'h00);
    chk("post_rst latency", payload_valid, 1);
    repeat (3) put(1'b0, 1'b0, 8'h00);
    chk("post_rst pv_count", n_pv - pv0, 1);
    chk("post_rst msg_len", msg_len, 44);
    chk("post_rst payload", payload, model(8'h50, 44));
    chk("post_rst errors", (n_le - le0) + (n_oe - oe0) + (n_ut - ut0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
